// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction formats, major opcodes and the
// encoder's output buffer entry.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/rv32i_encoder_if.sv
// Field-bundle input and instruction-word output handshakes of the encoder.
// master = producer/consumer side, slave = the encoder.
interface rv32i_encoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/rv32i_field_pack.sv
// Combinational packer: places decoded fields into an RV32I word and flags
// immediates that do not fit the selected format.
module rv32i_field_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output entry_t      result
);

  logic [31:0] word;
  logic        bad;
  logic        is_shift;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    word     = '0;
    bad      = 1'b0;
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        // Shift-immediate forms carry funct7 in the upper bits and a 5-bit shamt.
        if (is_shift) begin
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          bad  = |imm[31:5];
        end else begin
          word = {imm[11:0], rs1, funct3, rd, opcode};
          bad  = !((&imm[31:11]) || !(|imm[31:11]));
        end
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        bad  = |imm[11:0];
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      default: bad = 1'b1;
    endcase

    result.instr = bad ? 32'd0 : word;
    result.err   = bad;
  end

endmodule

// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder: handshake front end, two-entry FIFO output
// buffer and a saturating count of rejected bundles.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            reset,
  rv32i_encoder_if.slave bus
);

  entry_t           packed_entry;
  entry_t           head;
  entry_t           tail;
  occ_e             state;
  logic [CNT_W-1:0] err_cnt;
  logic             push;
  logic             pop;

  rv32i_field_pack u_pack (
    .fmt    (bus.fmt),
    .opcode (bus.opcode),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .imm    (bus.imm),
    .result (packed_entry)
  );

  // Ready depends only on the registered occupancy, never on out_ready.
  assign push = bus.in_valid && (state != FULL);
  assign pop  = (state != EMPTY) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two buffer slots are reset too, so the output word reads 0 straight out of reset.
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      err_cnt <= '0;
    end else begin
      // NOTE: state registers use <= so every branch sees the pre-edge values.
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= packed_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= packed_entry;
          end else if (push) begin
            tail  <= packed_entry;
            state <= FULL;
          end else if (pop) begin
            head  <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase

      if (push && packed_entry.err && !(&err_cnt)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_instr = head.instr;
  assign bus.out_err   = head.err;
  assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: directed encodings, backpressure,
// reset with a full buffer, randomized traffic and counter saturation.
module tb_rv32i_encoder;

  localparam int CNT_W = 8;

  logic clk;
  logic reset;

  int total = 0;
  int bad   = 0;
  int model_errs = 0;

  rv32i_encoder_if #(.CNT_W(CNT_W)) bus ();

  rv32i_encoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] edge_imms [12] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                  32'd4094, 32'd4096, 32'hFFFFF000, 32'hFFFFEFFE,
                                  32'd31, 32'd32, 32'h000FFFFE, 32'h00100000};

  // Reference encoder from the field-placement and range rules, using arithmetic.
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    logic [31:0] base;
    logic        e;
    s    = int'(im);
    e    = 1'b0;
    base = (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
    case (f)
      3'd0: w = base | (32'(f7) << 25) | (32'(s2) << 20);
      3'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e = (im > 32'd31);
          w = base | (32'(f7) << 25) | ((im & 32'd31) << 20);
        end else begin
          e = (s < -2048) || (s > 2047);
          w = base | ((im & 32'hFFF) << 20);
        end
      end
      3'd2: begin
        e = (s < -2048) || (s > 2047);
        w = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | 32'(op)
            | (((im >> 5) & 32'd127) << 25) | ((im & 32'd31) << 7);
      end
      3'd3: begin
        e = (s < -4096) || (s > 4095) || ((im & 32'd1) != 0);
        w = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | 32'(op)
            | (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25)
            | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7);
      end
      3'd4: begin
        e = (im % 32'd4096) != 0;
        w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
      end
      3'd5: begin
        e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || ((im & 32'd1) != 0);
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21)
            | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'd255) << 12)
            | (32'(d) << 7) | 32'(op);
      end
      default: begin
        e = 1'b1;
        w = 32'd0;
      end
    endcase
    if (e) w = 32'd0;
    return {e, w};
  endfunction

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    bus.fmt    = f;
    bus.opcode = op;
    bus.rd     = d;
    bus.rs1    = s1;
    bus.rs2    = s2;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.imm    = im;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    model_errs = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
        bus.out_err !== 1'b0 || bus.err_count !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b instr=%h err=%b cnt=%0d want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_instr, bus.out_err, bus.err_count);
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [6:0]  op;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] im;
    logic [31:0] want;
    logic        want_err;
    string       name;
  } vec_t;

  task automatic test_directed();
    vec_t v [14];
    v[0]  = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00510093, 1'b0, "addi"};
    v[1]  = '{3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0, "add"};
    v[2]  = '{3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,        32'h00512423, 1'b0, "sw"};
    v[3]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, "beq"};
    v[4]  = '{3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF, 1'b0, "jal"};
    v[5]  = '{3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0, "lui"};
    v[6]  = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd31,       32'h01F11093, 1'b0, "slli31"};
    v[7]  = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 7'b0100000, 32'd3,  32'h40315093, 1'b0, "srai3"};
    v[8]  = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80010093, 1'b0, "addi_min"};
    v[9]  = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h0,        1'b1, "err_i2048"};
    v[10] = '{3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        32'h0,        1'b1, "err_b3"};
    v[11] = '{3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0,        1'b1, "err_u"};
    v[12] = '{3'd7, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        32'h0,        1'b1, "err_fmt7"};
    v[13] = '{3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd32,       32'h0,        1'b1, "err_shamt32"};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_idle got rdy=%b vld=%b want 1 0", v[i].name, bus.in_ready, bus.out_valid);
      end
      drive(v[i].f, v[i].op, v[i].d, v[i].s1, v[i].s2, v[i].f3, v[i].f7, v[i].im);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== v[i].want || bus.out_err !== v[i].want_err) begin
        bad++;
        $display("FAIL %s got vld=%b instr=%h err=%b want 1 %h %b", v[i].name,
                 bus.out_valid, bus.out_instr, bus.out_err, v[i].want, v[i].want_err);
      end
      if (v[i].want_err) model_errs++;
      total++;
      if (bus.err_count !== CNT_W'(model_errs)) begin
        bad++;
        $display("FAIL %s_count got=%0d want=%0d", v[i].name, bus.err_count, model_errs);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] e [3];
    for (int i = 0; i < 3; i++)
      e[i] = ref_encode(3'd1, 7'b0010011, 5'(i + 4), 5'd7, 5'd0, 3'd0, 7'd0, 32'(i + 1));
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 7'b0010011, 5'(i + 4), 5'd7, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      bus.in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== (i == 0) || bus.out_valid !== 1'b1 || bus.out_instr !== e[0][31:0]) begin
        bad++;
        $display("FAIL bp_fill%0d got rdy=%b vld=%b instr=%h want %b 1 %h",
                 i, bus.in_ready, bus.out_valid, bus.out_instr, i == 0, e[0][31:0]);
      end
    end
    // Third bundle is still presented; release the output and drain.
    bus.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== e[i][31:0] || bus.out_err !== 1'b0 ||
          bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_drain%0d got vld=%b instr=%h err=%b rdy=%b want 1 %h 0 1",
                 i, bus.out_valid, bus.out_instr, bus.out_err, bus.in_ready, e[i][31:0]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.err_count !== CNT_W'(model_errs)) begin
      bad++;
      $display("FAIL bp_empty got vld=%b cnt=%0d want 0 %0d", bus.out_valid, bus.err_count, model_errs);
    end
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    drive(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.err_count === '0) begin
      bad++;
      $display("FAIL rst_prefill got rdy=%b vld=%b cnt=%0d want 0 1 nonzero",
               bus.in_ready, bus.out_valid, bus.err_count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 1'b0 ||
        bus.err_count !== '0) begin
      bad++;
      $display("FAIL rst_async got vld=%b instr=%h err=%b cnt=%0d want 0 0 0 0",
               bus.out_valid, bus.out_instr, bus.out_err, bus.err_count);
    end
    @(negedge clk);
    reset      = 1'b0;
    model_errs = 0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_q [$];
    logic [31:0] im;
    logic [32:0] e;
    bit          accept;
    bit          take;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== (exp_q.size() < 2) || bus.out_valid !== (exp_q.size() > 0)) begin
        bad++;
        $display("FAIL rnd_occ cyc=%0d got rdy=%b vld=%b want occupancy %0d",
                 cyc, bus.in_ready, bus.out_valid, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        total++;
        if (bus.out_instr !== exp_q[0][31:0] || bus.out_err !== exp_q[0][32]) begin
          bad++;
          $display("FAIL rnd_data cyc=%0d got instr=%h err=%b want %h %b",
                   cyc, bus.out_instr, bus.out_err, exp_q[0][31:0], exp_q[0][32]);
        end
      end
      total++;
      if (bus.err_count !== CNT_W'(model_errs)) begin
        bad++;
        $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, bus.err_count, model_errs);
      end
      case ($urandom_range(0, 4))
        0: im = $urandom();
        1: im = 32'($urandom_range(0, 63)) - 32'd32;
        2: im = $urandom() & 32'hFFFFF000;
        3: im = 32'($signed({$urandom_range(0, 1), 12'($urandom())}));
        default: im = edge_imms[$urandom_range(0, 11)];
      endcase
      drive(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
            5'($urandom()), 3'($urandom()), 7'($urandom()), im);
      bus.in_valid  = (cyc < 860) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      take   = bus.out_ready && (exp_q.size() > 0);
      accept = bus.in_valid && (exp_q.size() < 2);
      if (take) void'(exp_q.pop_front());
      if (accept) begin
        e = ref_encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm);
        exp_q.push_back(e);
        if (e[32] && model_errs < (1 << CNT_W) - 1) model_errs++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain got vld=%b left=%0d want 0 0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    int want;
    apply_reset();
    bus.out_ready = 1'b1;
    drive(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 300) bus.in_valid = 1'b0;
      want = (i < 255) ? i : 255;
      total++;
      if (bus.err_count !== CNT_W'(want) || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL sat_%0d got cnt=%0d rdy=%b want %0d 1", i, bus.err_count, bus.in_ready, want);
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.err_count !== 8'd255 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_final got cnt=%0d vld=%b want 255 0", bus.err_count, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_full();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
